srl_fifo_mc: RTL

//  Multi-channel SRL-based FIFO. CHANNELS independent first-word-fall-through queues, each built on an

---
 rtl/srl_fifo_pkg.sv | 29 ++
 rtl/srl_fifo_mc_if.sv | 25 ++
 rtl/srl_fifo_mc_lane.sv | 118 +++++++++++
 rtl/srl_fifo_mc.sv | 36 +++
 4 files changed

// File: rtl/srl_fifo_pkg.sv
// rtl/srl_fifo_pkg.sv - shared sizing helpers and default configuration for the multi-channel SRL FIFO
// Capacity follows SRL_FIFO_OUT_REG_EN: DEPTH without the head register, DEPTH+1 with it.
package srl_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int fifo_cap(input int depth);
`ifdef SRL_FIFO_OUT_REG_EN
        return depth + 1;
`else
        return depth;
`endif
    endfunction

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 9;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_AF_THRESH  = 7;
    localparam int CAPACITY       = fifo_cap(DEF_DEPTH);
    localparam int CNT_W          = clog2(CAPACITY + 1);

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/srl_fifo_mc_if.sv
// rtl/srl_fifo_mc_if.sv - packed per-lane write/read handshake bundle of the multi-channel FIFO
interface srl_fifo_mc_if #(
    parameter int DATA_WIDTH = srl_fifo_pkg::DEF_DATA_WIDTH,
    parameter int CHANNELS   = srl_fifo_pkg::DEF_CHANNELS,
    parameter int CNT_W      = srl_fifo_pkg::CNT_W
);
    logic [CHANNELS-1:0]            if_write;
    logic [CHANNELS*DATA_WIDTH-1:0] if_din;
    logic [CHANNELS-1:0]            if_full_n;
    logic [CHANNELS-1:0]            if_almost_full;
    logic [CHANNELS-1:0]            if_read;
    logic [CHANNELS*DATA_WIDTH-1:0] if_dout;
    logic [CHANNELS-1:0]            if_empty_n;
    logic [CHANNELS*CNT_W-1:0]      if_count;

    modport master (
        output if_write, if_din, if_read,
        input  if_full_n, if_almost_full, if_dout, if_empty_n, if_count
    );

    modport slave (
        input  if_write, if_din, if_read,
        output if_full_n, if_almost_full, if_dout, if_empty_n, if_count
    );
endinterface

// File: rtl/srl_fifo_mc_lane.sv
// rtl/srl_fifo_mc_lane.sv - one first-word-fall-through lane on a shift-register store
// SRL_FIFO_OUT_REG_EN adds a registered head entry in front of the SRL.
module srl_fifo_mc_lane
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 9,
    parameter int AF_THRESH  = 7,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full_n,
    output logic                  almost_full,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty_n,
    output logic [CNT_W-1:0]      count
);
    localparam int               CAP     = fifo_cap(DEPTH);
    localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [DATA_WIDTH-1:0] srl_q [DEPTH];
    logic [DATA_WIDTH-1:0] srl_d [DEPTH];
    logic [DATA_WIDTH-1:0] srl_rd;
    logic [CNT_W-1:0]      count_q, count_d, rd_addr;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  af_q, af_d;
    logic                  push, pop;

    assign push = write & full_n_q & ~reset;
    assign pop  = read & empty_n_q & ~reset;

    // Oldest entry sits at occupancy-1; an empty store yields an out-of-range address.
    assign srl_rd = (rd_addr < DEPTH_C) ? srl_q[rd_addr] : '0;

`ifdef SRL_FIFO_OUT_REG_EN
    logic [CNT_W-1:0]      srl_cnt_q, srl_cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  load;

    // empty_n_q doubles as the head-valid bit; refill whenever the head is consumed or vacant.
    assign load    = (pop | ~empty_n_q) & (srl_cnt_q != '0) & ~reset;
    assign rd_addr = srl_cnt_q - ONE_C;
    assign dout    = head_q;

    always_comb begin
        srl_cnt_d = srl_cnt_q;
        if (push && !load)
            srl_cnt_d = srl_cnt_q + ONE_C;
        else if (load && !push)
            srl_cnt_d = srl_cnt_q - ONE_C;
        head_d    = load ? srl_rd : head_q;
        empty_n_d = load | (empty_n_q & ~pop);
    end
`else
    assign rd_addr = count_q - ONE_C;
    assign dout    = srl_rd;

    always_comb begin
        empty_n_d = (count_d != '0);
    end
`endif

    always_comb begin
        srl_d = srl_q;
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--)
                srl_d[i] = srl_q[i-1];
            srl_d[0] = din;
        end
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + ONE_C;
        else if (pop && !push)
            count_d = count_q - ONE_C;
        full_n_d = (count_d != CAP_C);
        af_d     = (count_d >= AF_C);
    end

    always_ff @(posedge clk) begin
        srl_q <= srl_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            af_q      <= 1'b0;
`ifdef SRL_FIFO_OUT_REG_EN
            srl_cnt_q <= '0;
            head_q    <= '0;
`endif
        end else begin
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            af_q      <= af_d;
`ifdef SRL_FIFO_OUT_REG_EN
            srl_cnt_q <= srl_cnt_d;
            head_q    <= head_d;
`endif
        end
    end

    assign full_n      = full_n_q;
    assign empty_n     = empty_n_q;
    assign almost_full = af_q;
    assign count       = count_q;

endmodule

// File: rtl/srl_fifo_mc.sv
// rtl/srl_fifo_mc.sv - CHANNELS independent SRL FIFO lanes behind one packed bus
// Lane behaviour (incl. SRL_FIFO_OUT_REG_EN head register) lives in srl_fifo_mc_lane.
module srl_fifo_mc
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int AF_THRESH  = DEF_AF_THRESH,
    parameter int CNT_W      = clog2(fifo_cap(DEPTH) + 1)
) (
    input  logic          clk,
    input  logic          reset,
    srl_fifo_mc_if.slave  bus
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        srl_fifo_mc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_THRESH  (AF_THRESH),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .write       (bus.if_write[c]),
            .din         (bus.if_din[c*DATA_WIDTH +: DATA_WIDTH]),
            .full_n      (bus.if_full_n[c]),
            .almost_full (bus.if_almost_full[c]),
            .read        (bus.if_read[c]),
            .dout        (bus.if_dout[c*DATA_WIDTH +: DATA_WIDTH]),
            .empty_n     (bus.if_empty_n[c]),
            .count       (bus.if_count[c*CNT_W +: CNT_W])
        );
    end

endmodule
